// File: rtl/moore_seq_generator.sv
// Moore serial pattern transmitter: sends the low `len` bits of a captured pattern, MSB first,
// `reps` times back to back, then pulses done. Every output is a flop.
module moore_seq_generator #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(PAT_W);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic               out_q, out_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [PAT_W-1:0]   sel;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          pat_d = pattern;
          len_d = len;
          rep_d = (reps == '0) ? '0 : reps - REP_W'(1);
          if ((len != '0) && (len <= MaxLen)) begin
            state_d = StSend;
            idx_d   = len - LEN_W'(1);
          end else begin
            state_d = StDone;
          end
        end
      end
      StSend: begin
        if (idx_q != '0) begin
          idx_d = idx_q - LEN_W'(1);
        end else if (rep_q != '0) begin
          rep_d = rep_q - REP_W'(1);
          idx_d = len_q - LEN_W'(1);
        end else begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are computed from the next state so they land in flops alongside it.
    valid_d = (state_d == StSend);
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
    sel     = pat_d >> idx_d;
    out_d   = valid_d & sel[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_moore_seq_generator.sv
// Bench for moore_seq_generator: directed scenarios plus random transactions checked against a
// queue of expected bits built from the pattern/len/reps rules.
module tb_moore_seq_generator;

  localparam int unsigned PAT_W = 8;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned REP_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [LEN_W-1:0] len = '0;
  logic [REP_W-1:0] reps = '0;
  logic             out, valid, busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  moore_seq_generator #(
    .PAT_W(PAT_W),
    .LEN_W(LEN_W),
    .REP_W(REP_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .pattern(pattern),
    .len    (len),
    .reps   (reps),
    .out    (out),
    .valid  (valid),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic o, input logic v, input logic b,
                      input logic d);
    chk({tag, ".out"}, out, o);
    chk({tag, ".valid"}, valid, v);
    chk({tag, ".busy"}, busy, b);
    chk({tag, ".done"}, done, d);
  endtask

  // One full transaction; with disturb set, inputs are scrambled during SEND and start is
  // raised during DONE, none of which may affect the output.
  task automatic run_tx(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                        input logic [REP_W-1:0] r, input bit disturb);
    bit exp_q[$];
    int nr;
    nr = (r == 0) ? 1 : int'(r);
    if (l >= 1 && l <= PAT_W)
      for (int k = 0; k < nr; k++)
        for (int i = int'(l) - 1; i >= 0; i--) exp_q.push_back(p[i]);
    pattern = p;
    len     = l;
    reps    = r;
    start   = 1'b1;
    tick();
    start = 1'b0;
    foreach (exp_q[k]) begin
      chk4($sformatf("send[%0d]", k), exp_q[k], 1'b1, 1'b1, 1'b0);
      if (disturb) begin
        start   = 1'($urandom);
        pattern = PAT_W'($urandom);
        len     = LEN_W'($urandom);
        reps    = REP_W'($urandom);
      end
      tick();
    end
    start = disturb;
    chk4("done", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    start = 1'b0;
    chk4("idle", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    tick();
    tick();
    chk4("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk4("idle0", 1'b0, 1'b0, 1'b0, 1'b0);

    run_tx(8'b0000_0001, 4'd3, 4'd1, 1'b0);
    run_tx(8'b0001_0011, 4'd7, 4'd0, 1'b0);
    run_tx(8'b0000_0010, 4'd2, 4'd3, 1'b0);
    run_tx(8'hA5, 4'd0, 4'd2, 1'b0);
    run_tx(8'hA5, 4'd9, 4'd1, 1'b0);
    run_tx(8'hC3, 4'd8, 4'd15, 1'b0);

    // Reset on the 4th bit aborts without a done pulse, even with start high.
    pattern = 8'b0001_0011;
    len     = 4'd7;
    reps    = 4'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk4("bit4", 1'b0, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk4("abort", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk4("abort+1", 1'b0, 1'b0, 1'b0, 1'b0);
    run_tx(8'b0001_0011, 4'd7, 4'd0, 1'b0);

    run_tx(8'b0001_0011, 4'd7, 4'd0, 1'b1);

    for (int t = 0; t < 25; t++) begin
      run_tx(PAT_W'($urandom), LEN_W'($urandom), REP_W'($urandom_range(0, 4)),
             1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/moore_seq_generator.md
Name: moore_seq_generator

Overview:
- Moore-style serial pattern transmitter. Emits a programmed bit sequence, one bit per clock, on a single serial line.
- Acts as the driving end for the team's Moore sequence detectors. For example, pattern 001 or 0010011 drives a detector's inp directly.
- Used as a self-checking stimulus source and as an on-chip test-pattern source.
- All outputs are registered and derived from state only.

Parameters:
PAT_W, 8, maximum pattern length in bits
LEN_W, 4, width of len input; must hold PAT_W
REP_W, 4, width of reps input

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request transmission; sampled only in IDLE
pattern  input  PAT_W  bits to send; bit len-1 sent first, bit 0 last
len  input  LEN_W  number of bits per repetition, valid range 1..PAT_W
reps  input  REP_W  number of repetitions; 0 treated as 1
out  output  1  serial data bit (drives detector inp)
valid  output  1  high while out carries a pattern bit
busy  output  1  high from first bit through DONE cycle
done  output  1  one-cycle pulse after final bit

Behaviour:
- Single clock clk; reset is synchronous and active-high. When reset=1 at a rising edge: state=IDLE; out=0, valid=0, busy=0, done=0; internal counters cleared. Reset has priority over all other inputs, including mid-transmission. A transmission aborted by reset produces no done pulse.
- States: IDLE, SEND, DONE.
- IDLE:
  - out=0, valid=0, busy=0, done=0.
  - On an edge with start=1, capture pattern, len and reps into internal registers.
  - If len is in 1..PAT_W, go to SEND with bit index = len-1 and repetition counter = max(reps,1)-1.
  - If len=0 or len>PAT_W, go directly to DONE. No bits are sent and valid never asserts.
- SEND:
  - out = captured_pattern[index]; valid=1; busy=1.
  - Latency: the first bit appears in the cycle immediately after the edge that sampled start.
  - Each edge:
    - if index>0, decrement index.
    - else if repetition counter>0, decrement it and reload index=len-1. There is no gap between repetitions.
    - else go to DONE.
  - Each bit is held exactly one clock.
- DONE:
  - out=0, valid=0, busy=1, done=1 for exactly one cycle.
  - Next edge goes to IDLE unconditionally. start in DONE is ignored, so a new start needs IDLE, which gives a minimum one idle cycle between transmissions.
- Total SEND cycles = len × max(reps,1). Maximum is PAT_W × (2^REP_W−1) = 120 at defaults. The repetition counter width is REP_W; no overflow is possible.
- start is ignored in SEND and DONE.
- Changes to pattern, len or reps after capture have no effect until the next start.
- start held high continuously restarts on every IDLE visit (back-to-back transmissions separated by DONE+IDLE).
- Outputs must not change combinationally with any input. All outputs come from registered state/counters.

Test Plan:
1. Reset, then start=1 for one cycle with pattern=8'b0000_0001, len=3, reps=1 → out=0,0,1 on three consecutive cycles with valid=1; then done=1 for one cycle with out=0; then IDLE. A connected 001 detector asserts det after the final bit.
2. pattern=8'b0001_0011, len=7, reps=0 → out=0,0,1,0,0,1,1 (7 cycles, reps=0 behaves as 1); busy high for 8 cycles; exactly one done pulse.
3. pattern=8'b0000_0010, len=2, reps=3 → out=1,0,1,0,1,0 with valid held high continuously for 6 cycles, then done.
4. len=0 with start=1 → valid never asserts; done=1 one cycle after the start edge; busy=1 for that single cycle only.
5. Assert reset=1 during the 4th bit of scenario 2 → at the next edge out=0, valid=0, busy=0, no done pulse. After reset release, a fresh start sends the full sequence from bit 6.
6. Toggle start and change pattern to 8'hFF while in SEND (scenario 2) → transmitted bits unchanged; no restart; a start asserted during the DONE cycle is ignored.
